branch_target_predictor: RTL and testbench

BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

---
 rtl/branch_target_predictor.sv | 109 ++++++++++
 tb/tb_branch_target_predictor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, a combinational lookup and a one-cycle update.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_predictor #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              flush_all,
  output logic              mispredict,
  output logic [ADDR_W-1:0] correct_pc,
  output logic [15:0]       stat_updates,
  output logic [15:0]       stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;

  logic [ENTRIES-1:0] valid_reg;
  logic [1:0]         ctr_reg    [ENTRIES];
  logic [TAG_W-1:0]   tag_reg    [ENTRIES];
  logic [ADDR_W-1:0]  target_reg [ENTRIES];

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             upd_hit, commit, entry_we, data_we;
  logic [1:0]       ctr_next;

  assign if_idx  = if_pc[IDX_W:1];
  assign if_tag  = if_pc[ADDR_W-1:IDX_W+1];
  assign upd_idx = upd_pc[IDX_W:1];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+1];

  // Lookup reads pre-edge state, so a same-cycle update is only seen next cycle.
  assign pred_hit    = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
  assign pred_taken  = pred_hit && ctr_reg[if_idx][1];
  assign pred_target = pred_taken ? target_reg[if_idx] : if_pc + ADDR_W'(2);

  assign mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                      (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
  assign correct_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(2);

  assign upd_hit  = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
  assign commit   = upd_valid && !flush_all;
  assign entry_we = commit && (upd_hit || upd_taken);
  // A taken outcome always rewrites tag and target: on a hit the tag is unchanged.
  assign data_we  = commit && upd_taken && rst_n;

  always_comb begin
    ctr_next = ctr_reg[upd_idx];
    if (!upd_hit) begin
      ctr_next = 2'b10;
    end else if (upd_taken) begin
      if (ctr_reg[upd_idx] != 2'b11) ctr_next = ctr_reg[upd_idx] + 2'd1;
    end else begin
      if (ctr_reg[upd_idx] != 2'b00) ctr_next = ctr_reg[upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_reg[i] <= 2'b01;
    end else if (flush_all) begin
      valid_reg <= '0;
    end else if (entry_we) begin
      valid_reg[upd_idx] <= 1'b1;
      ctr_reg[upd_idx]   <= ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      tag_reg[upd_idx]    <= upd_tag;
      target_reg[upd_idx] <= upd_target;
    end
  end

`ifdef BTB_STATS_EN
  logic [15:0] stat_updates_reg, stat_mispredicts_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates_reg     <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (upd_valid && stat_updates_reg != 16'hFFFF)
        stat_updates_reg <= stat_updates_reg + 16'd1;
      if (mispredict && stat_mispredicts_reg != 16'hFFFF)
        stat_mispredicts_reg <= stat_mispredicts_reg + 16'd1;
    end
  end

  assign stat_updates     = stat_updates_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`else
  assign stat_updates     = 16'h0000;
  assign stat_mispredicts = 16'h0000;
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: directed scenarios followed by random traffic against a table model.
module tb_branch_target_predictor;
  localparam int ADDR_W  = 16;
  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] if_pc = '0;
  logic        pred_hit, pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [15:0] upd_pred_target = '0;
  logic        flush_all = 1'b0;
  logic        mispredict;
  logic [15:0] correct_pc, stat_updates, stat_mispredicts;

  always #5 clk = ~clk;

  branch_target_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush_all(flush_all), .mispredict(mispredict), .correct_pc(correct_pc),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic [15:0] pc;
    logic        hit, taken, mis;
    logic [15:0] target, cpc, su, sm;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int txn = 0;

  // Reference table: one slot per index, counter kept as a plain integer 0..3.
  bit          m_valid [ENTRIES];
  logic [15:0] m_tag   [ENTRIES];
  logic [15:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_su, m_sm;

  function automatic int slot_of(input logic [15:0] pc);
    return (int'(pc) / 2) % ENTRIES;
  endfunction

  function automatic logic [15:0] tag_of(input logic [15:0] pc);
    return 16'(int'(pc) / (2 * ENTRIES));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_su = 0;
    m_sm = 0;
  endfunction

  function automatic void model_lookup(input logic [15:0] pc, output logic hit,
                                       output logic taken, output logic [15:0] tgt);
    int s = slot_of(pc);
    hit   = m_valid[s] && (m_tag[s] == tag_of(pc));
    taken = hit && (m_ctr[s] >= 2);
    tgt   = taken ? m_tgt[s] : 16'((int'(pc) + 2) % 65536);
  endfunction

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h required=%h", name, txn, act, req);
    end
  endfunction

  task automatic cycle(input logic [15:0] pc, input logic uv, input logic [15:0] upc,
                       input logic ut, input logic [15:0] utgt, input logic upt,
                       input logic [15:0] uptgt, input logic fl, input logic rst);
    exp_t e;
    logic h, tk;
    logic [15:0] tg;
    @(posedge clk);
    #1;
    if_pc = pc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_pred_taken = upt; upd_pred_target = uptgt; flush_all = fl; rst_n = !rst;
    if (rst) model_reset();
    e.pc = pc;
    model_lookup(pc, e.hit, e.taken, e.target);
    e.mis = uv && ((ut != upt) || (ut && upt && utgt != uptgt));
    e.cpc = ut ? utgt : 16'((int'(upc) + 2) % 65536);
`ifdef BTB_STATS_EN
    e.su = 16'(m_su);
    e.sm = 16'(m_sm);
`else
    e.su = 16'h0;
    e.sm = 16'h0;
`endif
    sb.push_back(e);
    if (!rst) begin
      if (fl) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (uv) begin
        int s = slot_of(upc);
        model_lookup(upc, h, tk, tg);
        if (h) begin
          m_ctr[s] = ut ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
          if (ut) m_tgt[s] = utgt;
        end else if (ut) begin
          m_valid[s] = 1'b1;
          m_tag[s]   = tag_of(upc);
          m_tgt[s]   = utgt;
          m_ctr[s]   = 2;
        end
      end
      if (uv) begin
        if (m_su < 65535) m_su++;
        if (e.mis && m_sm < 65535) m_sm++;
      end
    end
  endtask

  task automatic look(input logic [15:0] pc);
    cycle(pc, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [15:0] pc, input logic [15:0] upc, input logic ut,
                     input logic [15:0] utgt, input logic upt, input logic [15:0] uptgt);
    cycle(pc, 1'b1, upc, ut, utgt, upt, uptgt, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are combinational, so each driven cycle presents one result at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn %0d if_pc=%h hit=%b taken=%b target=%h mis=%b cpc=%h su=%0d sm=%0d",
                 txn, e.pc, pred_hit, pred_taken, pred_target, mispredict, correct_pc,
                 stat_updates, stat_mispredicts);
        chk("pred_hit", 16'(pred_hit), 16'(e.hit));
        chk("pred_taken", 16'(pred_taken), 16'(e.taken));
        chk("pred_target", pred_target, e.target);
        chk("mispredict", 16'(mispredict), 16'(e.mis));
        chk("correct_pc", correct_pc, e.cpc);
        chk("stat_updates", stat_updates, e.su);
        chk("stat_mispredicts", stat_mispredicts, e.sm);
        txn++;
      end
    end
  end

  logic [15:0] pool [8] = '{16'h0040, 16'h0060, 16'h0041, 16'h0080, 16'hFFFE, 16'h0042, 16'h1040, 16'h0044};

  initial begin
    logic [15:0] pc, upc, tgt, ptgt;
    logic ut, upt, h, tk;
    model_reset();
    // Reset state and immediate lookup behaviour
    cycle(16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    look(16'h0040);
    // Allocation with mispredict, then hit
    upd(16'h0040, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0000);
    look(16'h0040);
    // Counter decays 10 -> 01 -> 00 and saturates
    upd(16'h0040, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0100);
    upd(16'h0040, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0042);
    upd(16'h0040, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0042);
    look(16'h0040);
    // Aliasing on a shared index
    upd(16'h0060, 16'h0060, 1'b1, 16'h0200, 1'b0, 16'h0000);
    look(16'h0060);
    look(16'h0040);
    // Flush wins over a simultaneous allocation
    upd(16'h0040, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0000);
    look(16'h0040);
    cycle(16'h0080, 1'b1, 16'h0080, 1'b1, 16'h0300, 1'b0, 16'h0000, 1'b1, 1'b0);
    look(16'h0040);
    look(16'h0080);
    // PC+2 wraps at the top of the address space
    look(16'hFFFE);
    upd(16'hFFFE, 16'hFFFE, 1'b0, 16'h1234, 1'b0, 16'h0000);
    // Taken with wrong carried target only
    upd(16'h0080, 16'h0080, 1'b1, 16'h0300, 1'b1, 16'h0304);
    // Reset in the middle of an update must discard it
    cycle(16'h0080, 1'b1, 16'h0044, 1'b1, 16'h0500, 1'b0, 16'h0, 1'b0, 1'b1);
    look(16'h0044);
    look(16'h0080);

    for (int n = 0; n < 400; n++) begin
      pc  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 7)];
      upc = pool[$urandom_range(0, 7)];
      ut  = ($urandom_range(0, 9) < 6);
      tgt = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 1) == 1) begin
        model_lookup(upc, h, tk, ptgt);
        upt = tk;
      end else begin
        upt  = 1'($urandom);
        ptgt = ($urandom_range(0, 1) == 1) ? tgt : 16'($urandom);
      end
      cycle(pc, ($urandom_range(0, 3) != 0), upc, ut, tgt, upt, ptgt,
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));
    end
    look(16'h0040);

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
